// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam int unsigned XLEN    = 16;
   localparam int unsigned OPC_W   = 4;

   localparam logic [XLEN-1:0]  NOP_INSTR = 16'h0000;
   localparam logic [OPC_W-1:0] HLT_OPC   = 4'hF;
   localparam logic [XLEN-1:0]  PC_RESET  = 16'h0000;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/dff.sv
// Single-bit register with synchronous reset and write enable.
module dff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   // Reset wins, otherwise capture when enabled.
   always_ff @(posedge clk) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/dff_16bit.sv
// 16-bit register with synchronous reset and write enable.
module dff_16bit #(
   parameter logic [15:0] RST_VAL = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] d,
   output logic [15:0] q
);

   // Reset wins, otherwise capture when enabled.
   always_ff @(posedge clk) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: load a fetched instruction, load a bubble, or hold.
module fetch_decode_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] BUBBLE_INSTR = NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [15:0] instr_in,
   input  logic [15:0] pc_plus2_in,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2,
   output logic        valid
);

   logic        wen;
   logic [15:0] instr_d;
   logic [15:0] pc_plus2_d;
   logic        valid_d;

   // Load takes the fetched word; bubble writes an invalid NOP; neither holds.
   always_comb begin
      wen        = load | bubble;
      instr_d    = BUBBLE_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
      if (load) begin
         instr_d    = instr_in;
         pc_plus2_d = pc_plus2_in;
         valid_d    = 1'b1;
      end
   end

   dff_16bit #(.RST_VAL(BUBBLE_INSTR)) u_instr (
      .clk (clk), .rst (rst), .en (wen), .d (instr_d), .q (instr)
   );

   dff_16bit #(.RST_VAL(16'h0000)) u_pc_plus2 (
      .clk (clk), .rst (rst), .en (wen), .d (pc_plus2_d), .q (pc_plus2)
   );

   dff #(.RST_VAL(1'b0)) u_valid (
      .clk (clk), .rst (rst), .en (wen), .d (valid_d), .q (valid)
   );

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, IF/ID register.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [3:0]  HLT_OPC   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_en,
   input  logic        flush,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic [15:0] pc_out,
   output logic        halted
);

   import fetch_stage_pkg::fetch_state_t;
   import fetch_stage_pkg::FETCH;
   import fetch_stage_pkg::DRAIN;
   import fetch_stage_pkg::HALTED;

   fetch_state_t state, state_n;
   logic [15:0]  pc, pc_n;
   logic [15:0]  redirect_pc, redirect_pc_n;
   logic [15:0]  pc_plus2;
   logic         id_load;
   logic         id_bubble;

   assign pc_plus2  = 16'(pc + 16'd2);
   assign imem_req  = (state != HALTED);
   assign imem_addr = pc;
   assign pc_out    = pc;
   assign halted    = (state == HALTED);

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         redirect_pc <= 16'h0000;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         redirect_pc <= redirect_pc_n;
      end
   end

   // Next-state, PC steering and IF/ID control; flush beats stall beats normal.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      redirect_pc_n = redirect_pc;
      id_load       = 1'b0;
      id_bubble     = 1'b0;
      unique case (state)
         FETCH: begin
            if (flush) begin
               id_bubble = 1'b1;
               if (imem_valid) begin
                  pc_n = branch_target;
               end else begin
                  // Request still in flight: remember target, discard its data later.
                  redirect_pc_n = branch_target;
                  state_n       = DRAIN;
               end
            end else if (stall_en) begin
               // Hold everything; memory re-presents the data next cycle.
            end else if (imem_valid) begin
               id_load = 1'b1;
               if (imem_rdata[15:12] == HLT_OPC) state_n = HALTED;
               else                              pc_n    = pc_plus2;
            end else begin
               id_bubble = 1'b1;
            end
         end
         DRAIN: begin
            id_bubble = flush | ~stall_en;
            if (imem_valid) begin
               pc_n    = flush ? branch_target : redirect_pc;
               state_n = FETCH;
            end else if (flush) begin
               redirect_pc_n = branch_target;
            end
         end
         HALTED: begin
            if (flush) begin
               pc_n      = branch_target;
               id_bubble = 1'b1;
               state_n   = FETCH;
            end else begin
               id_bubble = ~stall_en;
            end
         end
         default: begin
            state_n = FETCH;
         end
      endcase
   end

   fetch_decode_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
      .clk         (clk),
      .rst         (rst),
      .load        (id_load),
      .bubble      (id_bubble),
      .instr_in    (imem_rdata),
      .pc_plus2_in (pc_plus2),
      .instr       (if_id_instr),
      .pc_plus2    (if_id_pc_plus2),
      .valid       (if_id_valid)
   );

endmodule
